// File: rtl/rv32_csr_file_pkg.sv
// CSR address map, privilege/operation encodings and field positions for the RV32 machine-mode CSR file.
package rv32_csr_file_pkg;

  typedef enum logic [2:0] {
    PRIV_U = 3'b000,
    PRIV_S = 3'b001,
    PRIV_M = 3'b011
  } priv_mode_t;

  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_RW  = 2'b01,
    CSR_RS  = 2'b10,
    CSR_RC  = 2'b11
  } csr_op_t;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MSTATUSH      = 12'h310;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_TIME          = 12'hC01;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_TIMEH         = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;
  localparam logic [11:0] CSR_MCONFIGPTR    = 12'hF15;

  localparam int MSTATUS_MIE      = 3;
  localparam int MSTATUS_MPIE     = 7;
  localparam int MIP_MSIP         = 3;
  localparam int MIP_MTIP         = 7;
  localparam int MIP_MEIP         = 11;
  localparam int MCOUNTINHIBIT_CY = 0;
  localparam int MCOUNTINHIBIT_IR = 2;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
  localparam logic [31:0] MIE_MASK   = 32'h0000_0888;
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_MASK  = 32'hFFFF_FFFC;

  function automatic logic [31:0] csr_new_value(csr_op_t op, logic [31:0] old, logic [31:0] wdata);
    case (op)
      CSR_RW:  return wdata;
      CSR_RS:  return old | wdata;
      CSR_RC:  return old & ~wdata;
      default: return old;
    endcase
  endfunction

endpackage

// File: rtl/rv32_csr_counter64.sv
// 64-bit free-running counter with inhibit and independently writable 32-bit halves.
// Any half write takes the place of that cycle's increment; the low-half carry ripples in one cycle.
module rv32_csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        inhibit,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata;
      if (wr_hi) count[63:32] <= wdata;
    end else if (inc && !inhibit) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/rv32_csr_file.sv
// Machine-mode CSR file: combinational read/illegal decode, writes/trap/mret applied at the next edge.
// No backpressure: every request is serviced in the cycle it is presented.
module rv32_csr_file
  import rv32_csr_file_pkg::*;
#(
  parameter logic [31:0] MHARTID     = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_rs1_x0,
  input  logic [2:0]  priv,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instret_inc,
  input  logic        trap,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        irq_ext,
  input  logic [63:0] time_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_global,
  output logic        irq_pending
);

  csr_op_t     op;
  logic        st_mie, st_mpie, cy_inh, ir_inh;
  logic [31:0] mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q, mie_q;
  logic [31:0] mstatus, mip, csr_old, csr_new;
  logic [63:0] mcycle, minstret;
  logic        csr_known, wr_intent, csr_wr;

  assign op = csr_op_t'(csr_op);

  always_comb begin
    mstatus               = '0;
    mstatus[MSTATUS_MIE]  = st_mie;
    mstatus[MSTATUS_MPIE] = st_mpie;
    mstatus[12:11]        = 2'b11;
    mip                   = '0;
    mip[MIP_MSIP]         = irq_sw;
    mip[MIP_MTIP]         = irq_timer;
    mip[MIP_MEIP]         = irq_ext;
  end

  always_comb begin
    csr_known = 1'b1;
    csr_old   = '0;
    case (csr_addr)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID,
      CSR_MCONFIGPTR, CSR_MSTATUSH:    csr_old = '0;
      CSR_MHARTID:                     csr_old = MHARTID;
      CSR_MISA:                        csr_old = MISA_VALUE;
      CSR_MSTATUS:                     csr_old = mstatus;
      CSR_MIE:                         csr_old = mie_q;
      CSR_MIP:                         csr_old = mip;
      CSR_MTVEC:                       csr_old = mtvec_q;
      CSR_MSCRATCH:                    csr_old = mscratch_q;
      CSR_MEPC:                        csr_old = mepc_q;
      CSR_MCAUSE:                      csr_old = mcause_q;
      CSR_MTVAL:                       csr_old = mtval_q;
      CSR_MCOUNTINHIBIT: begin
        csr_old[MCOUNTINHIBIT_CY] = cy_inh;
        csr_old[MCOUNTINHIBIT_IR] = ir_inh;
      end
      CSR_MCYCLE, CSR_CYCLE:           csr_old = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:         csr_old = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:       csr_old = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH:     csr_old = minstret[63:32];
      CSR_TIME:                        csr_old = time_i[31:0];
      CSR_TIMEH:                       csr_old = time_i[63:32];
      default:                         csr_known = 1'b0;
    endcase
  end

  // RS/RC with a zero source are pure reads, so they may target read-only space.
  assign wr_intent   = (op == CSR_RW) || ((op == CSR_RS || op == CSR_RC) && !csr_rs1_x0);
  assign csr_illegal = csr_en && (!csr_known
                                  || ({1'b0, csr_addr[9:8]} > (priv & 3'b011))
                                  || (wr_intent && csr_addr[11:10] == 2'b11));
  assign csr_rdata   = csr_old;
  assign csr_new     = csr_new_value(op, csr_old, csr_wdata);
  assign csr_wr      = csr_en && wr_intent && !csr_illegal && !trap && !mret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      cy_inh     <= 1'b0;
      ir_inh     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & MTVEC_MASK;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mscratch_q <= '0;
      mie_q      <= '0;
    end else if (trap) begin
      st_mpie  <= st_mie;
      st_mie   <= 1'b0;
      mepc_q   <= trap_pc & MEPC_MASK;
      mcause_q <= trap_cause;
      mtval_q  <= trap_val;
    end else if (mret) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (csr_wr) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          st_mie  <= csr_new[MSTATUS_MIE];
          st_mpie <= csr_new[MSTATUS_MPIE];
        end
        CSR_MCOUNTINHIBIT: begin
          cy_inh <= csr_new[MCOUNTINHIBIT_CY];
          ir_inh <= csr_new[MCOUNTINHIBIT_IR];
        end
        CSR_MIE:      mie_q      <= csr_new & MIE_MASK;
        CSR_MTVEC:    mtvec_q    <= csr_new & MTVEC_MASK;
        CSR_MEPC:     mepc_q     <= csr_new & MEPC_MASK;
        CSR_MCAUSE:   mcause_q   <= csr_new;
        CSR_MTVAL:    mtval_q    <= csr_new;
        CSR_MSCRATCH: mscratch_q <= csr_new;
        default: ;
      endcase
    end
  end

  rv32_csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (1'b1),
    .inhibit (cy_inh),
    .wr_lo   (csr_wr && csr_addr == CSR_MCYCLE),
    .wr_hi   (csr_wr && csr_addr == CSR_MCYCLEH),
    .wdata   (csr_new),
    .count   (mcycle)
  );

  rv32_csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (instret_inc),
    .inhibit (ir_inh),
    .wr_lo   (csr_wr && csr_addr == CSR_MINSTRET),
    .wr_hi   (csr_wr && csr_addr == CSR_MINSTRETH),
    .wdata   (csr_new),
    .count   (minstret)
  );

  assign mtvec_o     = mtvec_q;
  assign mepc_o      = mepc_q;
  assign mie_global  = st_mie;
  assign irq_pending = st_mie && |(mip & mie_q);

endmodule

// File: tb/tb_rv32_csr_file.sv
// Randomized + directed bench for rv32_csr_file; expected responses are queued by the driver
// from an arithmetic reference model and checked by a separate negedge monitor.
module tb_rv32_csr_file;

  localparam logic [31:0] HART  = 32'd5;
  localparam logic [31:0] TVEC0 = 32'h0000_0100;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        csr_en = 0, csr_rs1_x0 = 0, instret_inc = 0, trap = 0, mret = 0;
  logic        irq_sw = 0, irq_timer = 0, irq_ext = 0, csr_illegal, mie_global, irq_pending;
  logic [1:0]  csr_op = 0;
  logic [2:0]  priv = 3'b011;
  logic [11:0] csr_addr = 0;
  logic [31:0] csr_wdata = 0, trap_cause = 0, trap_pc = 0, trap_val = 0;
  logic [31:0] csr_rdata, mtvec_o, mepc_o;
  logic [63:0] time_i = 0;

  int checks = 0, errors = 0;

  rv32_csr_file #(.MHARTID(HART), .MTVEC_RESET(TVEC0)) dut (
    .clk(clk), .rst_n(rst_n), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rs1_x0(csr_rs1_x0), .priv(priv), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .instret_inc(instret_inc), .trap(trap), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_val(trap_val), .mret(mret), .irq_sw(irq_sw), .irq_timer(irq_timer),
    .irq_ext(irq_ext), .time_i(time_i), .mtvec_o(mtvec_o), .mepc_o(mepc_o),
    .mie_global(mie_global), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic        ill;
    logic [31:0] rdata, mtvec, mepc;
    logic        mie, pend;
  } exp_t;
  exp_t exp_q[$];

  // Reference state in architectural terms.
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch, m_mie_r, m_inh;
  logic [63:0] m_cycle, m_instret;

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mtvec = TVEC0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_mscratch = 0; m_mie_r = 0; m_inh = 0; m_cycle = 0; m_instret = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic void model_read(input logic [11:0] a, input logic [31:0] mip,
                                     output logic ok, output logic [31:0] v);
    ok = 1; v = 0;
    case (a)
      12'hF11, 12'hF12, 12'hF13, 12'hF15, 12'h310: v = 0;
      12'hF14: v = HART;
      12'h301: v = 32'h4000_0100;
      12'h300: v = 32'h0000_1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h304: v = m_mie_r;
      12'h344: v = mip;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h320: v = m_inh;
      12'hB00, 12'hC00: v = m_cycle[31:0];
      12'hB80, 12'hC80: v = m_cycle[63:32];
      12'hB02, 12'hC02: v = m_instret[31:0];
      12'hB82, 12'hC82: v = m_instret[63:32];
      12'hC01: v = time_i[31:0];
      12'hC81: v = time_i[63:32];
      default: ok = 0;
    endcase
  endfunction

  // Predict this cycle's outputs, queue them, advance the model, then let the clock edge happen.
  task automatic step();
    exp_t e;
    logic ok, wi;
    logic [31:0] mip, old, nv;
    logic [63:0] nc, ni;
    mip = (32'(irq_sw) << 3) | (32'(irq_timer) << 7) | (32'(irq_ext) << 11);
    model_read(csr_addr, mip, ok, old);
    wi = (csr_op == 2'b01) || (csr_op >= 2'b10 && !csr_rs1_x0);
    e.addr  = csr_addr;
    e.ill   = !ok || (priv[1:0] < csr_addr[9:8]) || (wi && csr_addr[11:10] == 2'b11);
    e.rdata = old;
    e.mtvec = m_mtvec;
    e.mepc  = m_mepc;
    e.mie   = m_mie;
    e.pend  = m_mie && ((mip & m_mie_r) != 0);
    if (csr_en) exp_q.push_back(e);
    nc = m_inh[0] ? m_cycle : m_cycle + 1;
    ni = (m_inh[2] || !instret_inc) ? m_instret : m_instret + 1;
    if (trap) begin
      m_mpie = m_mie; m_mie = 0; m_mepc = {trap_pc[31:2], 2'b00};
      m_mcause = trap_cause; m_mtval = trap_val;
    end else if (mret) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (csr_en && wi && !e.ill) begin
      nv = (csr_op == 2'b01) ? csr_wdata : (csr_op == 2'b10) ? (old | csr_wdata) : (old & ~csr_wdata);
      case (csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie_r = nv & 32'h888;
        12'h305: m_mtvec = {nv[31:2], 1'b0, nv[0]};
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = {nv[31:2], 2'b00};
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'h320: m_inh = nv & 32'h5;
        12'hB00: nc = {m_cycle[63:32], nv};
        12'hB80: nc = {nv, m_cycle[31:0]};
        12'hB02: ni = {m_instret[63:32], nv};
        12'hB82: ni = {nv, m_instret[31:0]};
        default: ;
      endcase
    end
    m_cycle = nc; m_instret = ni;
    @(posedge clk); #1;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d, input logic x0);
    csr_en = 1; csr_op = op; csr_addr = a; csr_wdata = d; csr_rs1_x0 = x0;
    step();
    csr_en = 0; csr_op = 0; csr_rs1_x0 = 0;
  endtask

  task automatic rd(input logic [11:0] a);
    csr(2'b10, a, 32'h0, 1'b1);
  endtask

  // Monitor: every cycle the DUT is presented a CSR access, compare against the queued prediction.
  always @(negedge clk) begin
    if (rst_n && csr_en) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("illegal@%h", e.addr), 32'(csr_illegal), 32'(e.ill));
        if (!e.ill) chk($sformatf("rdata@%h", e.addr), csr_rdata, e.rdata);
        chk("mtvec_o", mtvec_o, e.mtvec);
        chk("mepc_o", mepc_o, e.mepc);
        chk("mie_global", 32'(mie_global), 32'(e.mie));
        chk("irq_pending", 32'(irq_pending), 32'(e.pend));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic [11:0] addrs [28] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
    12'h343, 12'h344, 12'h320, 12'h310, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hF15, 12'hB00,
    12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82, 12'h7C0, 12'h345};
  logic [2:0] privs [3] = '{3'b000, 3'b001, 3'b011};

  initial begin
    model_reset();
    #3 rst_n = 0;
    #1;
    chk("reset_mtvec_o", mtvec_o, TVEC0);
    chk("reset_mepc_o", mepc_o, 32'h0);
    chk("reset_mie_global", 32'(mie_global), 32'h0);
    chk("reset_irq_pending", 32'(irq_pending), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Reset values and read-only space.
    rd(12'h305); rd(12'hF14); rd(12'h300);
    csr(2'b01, 12'hF11, 32'h1234, 0);
    rd(12'hF11); rd(12'h301);
    csr(2'b01, 12'h301, 32'hFFFF_FFFF, 0);
    rd(12'h301);

    // Set/clear on mscratch.
    csr(2'b01, 12'h340, 32'hA5A5_0000, 0);
    csr(2'b10, 12'h340, 32'h0000_00FF, 0);
    rd(12'h340);
    csr(2'b11, 12'h340, 32'hA500_0000, 0);
    rd(12'h340);
    csr(2'b10, 12'hB00, 32'hFFFF_FFFF, 1);

    // Interrupt enable, trap entry, return.
    csr(2'b10, 12'h300, 32'h8, 0);
    csr(2'b01, 12'h304, 32'hFFFF_F880, 0);
    irq_timer = 1;
    rd(12'h344);
    trap = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h0000_1236; trap_val = 32'hDEAD_BEEF;
    step();
    trap = 0;
    rd(12'h300); rd(12'h341); rd(12'h342); rd(12'h343);
    mret = 1; step(); mret = 0;
    rd(12'h300);
    irq_timer = 0;

    // Counter wrap and write/increment collision.
    csr(2'b01, 12'hB80, 32'hFFFF_FFFF, 0);
    csr(2'b01, 12'hB00, 32'hFFFF_FFFE, 0);
    rd(12'hB00); rd(12'hB00); rd(12'hB00); rd(12'hB80);
    instret_inc = 1;
    csr(2'b01, 12'hB02, 32'h0000_1234, 0);
    instret_inc = 0;
    rd(12'hB02); rd(12'hB82);

    // Trap, mret and an mepc write in one cycle.
    trap = 1; mret = 1; trap_pc = 32'h0000_2000; trap_cause = 32'h2;
    csr(2'b01, 12'h341, 32'h40, 0);
    trap = 0; mret = 0;
    rd(12'h341); rd(12'h300);

    // User-mode access checks.
    priv = 3'b000;
    rd(12'h300); rd(12'hC00);
    time_i = 64'h0123_4567_89AB_CDEF;
    rd(12'hC01); rd(12'hC81);
    csr(2'b01, 12'hC00, 32'h1, 0);
    priv = 3'b011;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      csr_en      = ($urandom_range(3, 0) != 0);
      csr_op      = 2'($urandom_range(3, 0));
      csr_addr    = addrs[$urandom_range(27, 0)];
      csr_wdata   = $urandom;
      csr_rs1_x0  = ($urandom_range(3, 0) == 0);
      priv        = privs[$urandom_range(2, 0)];
      instret_inc = 1'($urandom);
      trap        = ($urandom_range(15, 0) == 0);
      mret        = ($urandom_range(15, 0) == 0);
      trap_cause  = $urandom; trap_pc = $urandom; trap_val = $urandom;
      irq_sw      = 1'($urandom); irq_timer = 1'($urandom); irq_ext = 1'($urandom);
      time_i      = {$urandom, $urandom};
      step();
    end
    csr_en = 0; trap = 0; mret = 0; instret_inc = 0; priv = 3'b011;
    irq_sw = 0; irq_timer = 0; irq_ext = 0;

    // Asynchronous reset in the middle of a write.
    csr(2'b01, 12'h341, 32'h88, 0);
    csr(2'b01, 12'h305, 32'hFFFF_FF00, 0);
    csr(2'b10, 12'h300, 32'h8, 0);
    rd(12'h341);
    csr_en = 1; csr_op = 2'b01; csr_addr = 12'h341; csr_wdata = 32'h44;
    #2 rst_n = 0;
    #1;
    csr_en = 0;
    chk("midreset_mepc_o", mepc_o, 32'h0);
    chk("midreset_mtvec_o", mtvec_o, TVEC0);
    chk("midreset_mie_global", 32'(mie_global), 32'h0);
    model_reset();
    exp_q.delete();
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1;
    rd(12'h341); rd(12'h300); rd(12'hB00);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
